// File: rtl/pipe_muldiv_ctrl.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO; stalls HI/LO consumers in ID.
// Latency: accept edge + 32 RUN edges + 1 FIX edge; md_done pulses the cycle after FIX.
// Backpressure: md_stall (combinational) holds any muldiv or mfhi/mflo in ID while busy.
module pipe_muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ID_md_valid,
  input  logic [1:0]  ID_md_op,
  input  logic        ID_hilo_read,
  input  logic        ID_advance,
  input  logic [31:0] ID_a,
  input  logic [31:0] ID_b,
  output logic        md_stall,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d, divz_q, divz_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d, a_orig_q, a_orig_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        accept, signed_op, in_sa, in_sb;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic        no_borrow;
  logic [31:0] rem_diff;
  logic [63:0] prod_fix;

  assign md_stall = busy_q & (ID_md_valid | ID_hilo_read);
  assign md_busy  = busy_q;
  assign md_done  = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    divz_d   = divz_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    a_orig_d = a_orig_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    accept    = (state_q == IDLE) & ID_md_valid & ID_advance & ~md_stall;
    signed_op = ~ID_md_op[0];
    in_sa     = signed_op & ID_a[31];
    in_sb     = signed_op & ID_b[31];
    abs_a     = in_sa ? -ID_a : ID_a;
    abs_b     = in_sb ? -ID_b : ID_b;

    // Shift-add: the 33-bit sum keeps the carry that the right shift pulls down.
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? ma_q : 32'd0)};
    // Restoring divide: shifted remainder can briefly need 33 bits.
    rem_sh    = acc_q[63:31];
    no_borrow = (rem_sh >= {1'b0, mb_q});
    rem_diff  = rem_sh[31:0] - mb_q;
    prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = ID_md_op;
          sa_d     = in_sa;
          sb_d     = in_sb;
          ma_d     = abs_a;
          mb_d     = abs_b;
          divz_d   = (abs_b == 32'd0);
          a_orig_d = ID_a;
          acc_d    = ID_md_op[1] ? {32'd0, abs_a} : {32'd0, abs_b};
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          acc_d = no_borrow ? {rem_diff, acc_q[30:0], 1'b1}
                            : {rem_sh[31:0], acc_q[30:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        if (!op_q[1]) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (divz_q) begin
          hi_d = a_orig_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          lo_d = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
          hi_d = sa_q ? -acc_q[63:32] : acc_q[63:32];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= 2'b00;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      divz_q   <= 1'b0;
      ma_q     <= 32'd0;
      mb_q     <= 32'd0;
      a_orig_q <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      divz_q   <= divz_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      a_orig_q <= a_orig_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// Directed plus random bench for pipe_muldiv_ctrl against an arithmetic HI/LO model.
module tb_pipe_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ID_md_valid = 1'b0;
  logic [1:0]  ID_md_op = 2'b00;
  logic        ID_hilo_read = 1'b0;
  logic        ID_advance = 1'b0;
  logic [31:0] ID_a = 32'd0;
  logic [31:0] ID_b = 32'd0;
  logic        md_stall, md_busy, md_done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  pipe_muldiv_ctrl #(.ITER(32)) dut (
    .clock(clock), .resetn(resetn),
    .ID_md_valid(ID_md_valid), .ID_md_op(ID_md_op), .ID_hilo_read(ID_hilo_read),
    .ID_advance(ID_advance), .ID_a(ID_a), .ID_b(ID_b),
    .md_stall(md_stall), .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MIPS HI/LO semantics from plain integer arithmetic; returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(a));
    sy = longint'($signed(b));
    case (op)
      OP_MULT:  res = 64'(sx * sy);
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Presents an op for one accept edge; returns at the negedge after that edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_read);
    @(negedge clock);
    ID_md_valid = 1'b1; ID_md_op = op; ID_a = a; ID_b = b; ID_advance = 1'b1;
    @(posedge clock);
    #1;
    ID_md_valid = 1'b0;
    ID_hilo_read = hold_read;
    @(negedge clock);
  endtask

  task automatic finish_op(input string tag, input logic [63:0] exp, input bit hold_read);
    logic [31:0] prev_hi, prev_lo;
    int busy_cnt, done_cnt, stall_cnt;
    bit moved;
    prev_hi = hi; prev_lo = lo;
    busy_cnt = 0; done_cnt = 0; stall_cnt = 0; moved = 0;
    for (int i = 0; i < 40; i++) begin
      if (!md_busy) break;
      busy_cnt++;
      if (md_done) done_cnt++;
      if (md_stall) stall_cnt++;
      if (hi !== prev_hi || lo !== prev_lo) moved = 1;
      @(negedge clock);
    end
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, " hilo_held"}, 64'(moved), 64'd0);
    chk({tag, " done_early"}, 64'(done_cnt), 64'd0);
    if (hold_read) begin
      chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'd33);
      chk({tag, " stall_idle"}, 64'(md_stall), 64'd0);
    end
    chk({tag, " done"}, 64'(md_done), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    chk({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
    #1;
    ID_hilo_read = 1'b0;
    @(negedge clock);
    chk({tag, " done_off"}, 64'(md_done), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit hold_read);
    start_op(op, a, b, hold_read);
    finish_op(tag, model(op, a, b), hold_read);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int done_seen;

    // Reset state
    #3;
    chk("rst busy", 64'(md_busy), 64'd0);
    chk("rst done", 64'(md_done), 64'd0);
    chk("rst stall", 64'(md_stall), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Directed arithmetic cases
    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu max hi_const", 64'(hi), 64'hFFFF_FFFE);
    run_op("mult -3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    chk("mult -3x5 lo_const", 64'(lo), 64'hFFFF_FFF1);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div -7/2 lo_const", 64'(lo), 64'hFFFF_FFFD);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div ovf lo_const", 64'(lo), 64'h8000_0000);
    run_op("divu 7/0", OP_DIVU, 32'd7, 32'd0, 1'b0);
    run_op("div -7/0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);

    // mfhi held in ID across the whole operation
    run_op("stall mult", OP_MULT, 32'h1234_5678, 32'h8765_4321, 1'b1);

    // Other hazard blocks advance: no accept until ID_advance rises
    @(negedge clock);
    ID_md_valid = 1'b1; ID_md_op = OP_MULTU; ID_a = 32'd1000; ID_b = 32'd3000; ID_advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("noadv busy", 64'(md_busy), 64'd0);
    end
    ID_advance = 1'b1;
    @(posedge clock);
    #1;
    ID_md_valid = 1'b0;
    @(negedge clock);
    finish_op("adv multu", model(OP_MULTU, 32'd1000, 32'd3000), 1'b0);

    // Reset mid-RUN abandons the op
    start_op(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    repeat (10) @(negedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst busy", 64'(md_busy), 64'd0);
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    chk("midrst done", 64'(md_done), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (md_done || md_busy) done_seen++;
    end
    chk("midrst no_done", 64'(done_seen), 64'd0);
    run_op("post rst", OP_DIVU, 32'd100, 32'd7, 1'b0);

    // Random ops against the model
    for (int n = 0; n < 20; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
